// File: rtl/seg7_shift_driver_pkg.sv
// Shared definitions for the seven-segment display path (decoder, scanner, shift driver).
// Latency: n/a (types, constants and a constant-evaluable helper only).
// Backpressure: n/a.
// Contents: SEG_WIDTH, BITS_PER_DIGIT, the shift-driver FSM state encoding, clog2().
package seg7_shift_driver_pkg;

   localparam int SEG_WIDTH      = 7;
   localparam int BITS_PER_DIGIT = 8;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SHIFT_LO = 3'd1,
      SHIFT_HI = 3'd2,
      LATCH    = 3'd3,
      GAP      = 3'd4
   } state_t;

   // Bits needed to hold values 0..value-1; never less than 1.
   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      if (r == 0) r = 1;
      return r;
   endfunction

endpackage

// File: rtl/seg7_sclk_divider.sv
// Phase timer for the serial clock: counts 0..CLK_DIV-1, flags the last cycle of a phase.
// Latency: phase_end is a decode of the counter register; reload takes effect next cycle.
// Backpressure: none; free-running while reload is low.
// Ports: clk, rst_n (sync, active-low), reload (restart phase at 0),
//        phase_end (current cycle is last of phase), phase_end_nxt (next cycle will be last).
module seg7_sclk_divider #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic reload,
   output logic phase_end,
   output logic phase_end_nxt
);

   localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

   logic [7:0] cnt;
   logic [7:0] cnt_nxt;

   always_comb begin
      cnt_nxt = cnt + 8'd1;
      if (reload || phase_end) cnt_nxt = '0;
   end

   assign phase_end     = (cnt == LAST);
   // Lets the owner register outputs that must line up with the last phase cycle.
   assign phase_end_nxt = (cnt_nxt == LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) cnt <= '0;
      else        cnt <= cnt_nxt;
   end

endmodule

// File: rtl/seg7_shift_driver.sv
// Snapshots digit segment patterns + dps on i_start and shifts them MSB-first into a 74HC595 chain, then latches.
// Latency: o_busy high for 2*CLK_DIV*(8*NUM_DIGITS+1) cycles from the cycle after i_start; o_done on the last one.
// Backpressure: i_start while busy is dropped, not queued; all outputs are flops.
// Ports: i_clk, i_rst_n (sync, active-low), i_start, i_segments (digit k at [7k+6:7k], bit6=a..bit0=g), i_dp,
//        o_sclk, o_sdata (valid on o_sclk rise), o_latch, o_busy, o_done.
// Build option: define SEG7_SHIFT_INVERT_EN to invert every transmitted byte (common-anode displays).
module seg7_shift_driver
   import seg7_shift_driver_pkg::*;
#(
   parameter int NUM_DIGITS = 6,
   parameter int CLK_DIV    = 4
) (
   input  logic                              i_clk,
   input  logic                              i_rst_n,
   input  logic                              i_start,
   input  logic [SEG_WIDTH*NUM_DIGITS-1:0]   i_segments,
   input  logic [NUM_DIGITS-1:0]             i_dp,
   output logic                              o_sclk,
   output logic                              o_sdata,
   output logic                              o_latch,
   output logic                              o_busy,
   output logic                              o_done
);

   localparam int NBITS = BITS_PER_DIGIT * NUM_DIGITS;
   localparam int CNT_W = clog2(NBITS + 1);

   state_t             state, state_nxt;
   logic [NBITS-1:0]   frame;
   logic [NBITS-1:0]   shreg, shreg_nxt;
   logic [CNT_W-1:0]   bit_cnt, bit_cnt_nxt;
   logic               reload;
   logic               phase_end;
   logic               phase_end_nxt;
   logic               shifting_nxt;

   // Digit NUM_DIGITS-1 lands in the top byte so it leaves first.
   always_comb begin
      frame = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         frame[k*BITS_PER_DIGIT +: BITS_PER_DIGIT] = {i_segments[k*SEG_WIDTH +: SEG_WIDTH], i_dp[k]};
      end
`ifdef SEG7_SHIFT_INVERT_EN
      frame = ~frame;
`endif
   end

   // Counter restarts on every state change and is held at 0 while idle.
   assign reload = (state_nxt != state) || (state == IDLE);

   seg7_sclk_divider #(
      .CLK_DIV       (CLK_DIV)
   ) u_div (
      .clk           (i_clk),
      .rst_n         (i_rst_n),
      .reload        (reload),
      .phase_end     (phase_end),
      .phase_end_nxt (phase_end_nxt)
   );

   always_comb begin
      state_nxt   = state;
      shreg_nxt   = shreg;
      bit_cnt_nxt = bit_cnt;
      case (state)
         IDLE: begin
            // The shift register doubles as the snapshot: later input changes cannot reach it.
            if (i_start) begin
               state_nxt   = SHIFT_LO;
               shreg_nxt   = frame;
               bit_cnt_nxt = '0;
            end
         end
         SHIFT_LO: begin
            if (phase_end) state_nxt = SHIFT_HI;
         end
         SHIFT_HI: begin
            if (phase_end) begin
               shreg_nxt   = {shreg[NBITS-2:0], 1'b0};
               bit_cnt_nxt = bit_cnt + 1'b1;
               state_nxt   = (bit_cnt == CNT_W'(NBITS - 1)) ? LATCH : SHIFT_LO;
            end
         end
         LATCH: begin
            if (phase_end) state_nxt = GAP;
         end
         GAP: begin
            if (phase_end) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign shifting_nxt = (state_nxt == SHIFT_LO) || (state_nxt == SHIFT_HI);

   // Outputs are registered from next-state values so they align with the state they describe.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state   <= IDLE;
         shreg   <= '0;
         bit_cnt <= '0;
         o_sclk  <= 1'b0;
         o_sdata <= 1'b0;
         o_latch <= 1'b0;
         o_busy  <= 1'b0;
         o_done  <= 1'b0;
      end else begin
         state   <= state_nxt;
         shreg   <= shreg_nxt;
         bit_cnt <= bit_cnt_nxt;
         o_sclk  <= (state_nxt == SHIFT_HI);
         o_sdata <= shifting_nxt & shreg_nxt[NBITS-1];
         o_latch <= (state_nxt == LATCH);
         o_busy  <= (state_nxt != IDLE);
         o_done  <= (state_nxt == GAP) && phase_end_nxt;
      end
   end

endmodule
